// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam logic STROBE_OFF = 1'b1;

  typedef struct packed {
    logic cs_n;
    logic we_n;
    logic oe_n;
  } strobes_t;

  localparam strobes_t STROBES_IDLE = '{cs_n: STROBE_OFF, we_n: STROBE_OFF, oe_n: STROBE_OFF};

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and control signals of the arbiter; slave = arbiter side.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
);
  logic                  en;
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_valid;
  logic                  if_stall;
  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic [DATA_WIDTH-1:0] dm_rdata;
  logic                  dm_done;
  logic                  dm_stall;
  logic                  mem_cs_n;
  logic                  mem_we_n;
  logic                  mem_oe_n;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  busy;

  modport slave (
    input  en, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_valid, if_stall, dm_rdata, dm_done, dm_stall,
           mem_cs_n, mem_we_n, mem_oe_n, mem_addr, mem_wdata, busy
  );

  modport master (
    output en, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_valid, if_stall, dm_rdata, dm_done, dm_stall,
           mem_cs_n, mem_we_n, mem_oe_n, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter_prio.sv
// Fetch/data grant selection: data wins unless fetch has been passed over STARVE_LIMIT times.
module mem_arb_prio #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic if_req,
  input  logic dm_req,
  output logic grant_if,
  output logic grant_dm
);
  localparam int unsigned   CW    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q, starve_d;
  logic          force_if;

  assign force_if = if_req && (starve_q == LIMIT);

  always_comb begin
    grant_if = arb_en && if_req && (force_if || !dm_req);
    grant_dm = arb_en && dm_req && !force_if;
  end

  // Count only data grants that actually bypassed a waiting fetch; saturate at the limit.
  always_comb begin
    starve_d = starve_q;
    if (grant_if) begin
      starve_d = '0;
    end else if (grant_dm) begin
      if (!if_req)                starve_d = '0;
      else if (starve_q != LIMIT) starve_d = starve_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch port and the load/store port.
// State and owner encodings formerly in the shared include now come from the package.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned   LW       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LW-1:0] CNT_LOAD = LW'(MEM_LATENCY - 1);

  state_t                state_q, state_d;
  owner_t                owner_q, owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [LW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  arb_en, grant_if, grant_dm;
  strobes_t              strobes;

  assign arb_en = (state_q == ST_IDLE) && bus.en;

  mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk      (clk),
    .rst_n    (rst_n),
    .arb_en   (arb_en),
    .if_req   (bus.if_req),
    .dm_req   (bus.dm_req),
    .grant_if (grant_if),
    .grant_dm (grant_dm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_if) begin
          state_d = ST_ACCESS;
          owner_d = OWN_IF;
          we_d    = 1'b0;
          addr_d  = bus.if_addr;
          cnt_d   = CNT_LOAD;
        end else if (grant_dm) begin
          state_d = ST_ACCESS;
          owner_d = OWN_DM;
          we_d    = bus.dm_we;
          addr_d  = bus.dm_addr;
          wdata_d = bus.dm_wdata;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          if (!we_q) begin
            if (owner_q == OWN_IF) if_rdata_d = bus.mem_rdata;
            else                   dm_rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - LW'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes decode straight from the state register so async reset drops them at once.
  always_comb begin
    strobes = STROBES_IDLE;
    if (state_q == ST_ACCESS) begin
      strobes.cs_n = 1'b0;
      strobes.we_n = ~we_q;
      strobes.oe_n = we_q;
    end
  end

  assign bus.mem_cs_n  = strobes.cs_n;
  assign bus.mem_we_n  = strobes.we_n;
  assign bus.mem_oe_n  = strobes.oe_n;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_valid  = (state_q == ST_RESP) && (owner_q == OWN_IF);
  assign bus.dm_done   = (state_q == ST_RESP) && (owner_q == OWN_DM);
  assign bus.if_stall  = bus.if_req & ~bus.if_valid;
  assign bus.dm_stall  = bus.dm_req & ~bus.dm_done;
  assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: latency-1 arbiter with a small memory model, plus a latency-4 copy for mid-access reset.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst4_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  mem_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(11)) bus1 ();
  mem_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(11)) bus4 ();

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .MEM_LATENCY(1), .STARVE_LIMIT(3)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .MEM_LATENCY(4), .STARVE_LIMIT(3)) u_dut4 (
    .clk   (clk),
    .rst_n (rst4_n),
    .bus   (bus4)
  );

  logic [31:0] mem1 [0:2047];
  logic        bd_we = 1'b0;
  logic [10:0] bd_addr = '0;
  logic [31:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) mem1[bd_addr] <= bd_data;
    else if (!bus1.mem_cs_n && !bus1.mem_we_n) mem1[bus1.mem_addr] <= bus1.mem_wdata;
  end
  assign bus1.mem_rdata = bus1.mem_oe_n ? 32'h0 : mem1[bus1.mem_addr];
  assign bus4.mem_rdata = {21'h0, bus4.mem_addr} ^ 32'hA5A5_0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [7:0] seq;
  int nev, ndm, low4;
  logic stall_ok;

  initial begin
    bus1.en = 0; bus1.if_req = 0; bus1.if_addr = '0; bus1.dm_req = 0;
    bus1.dm_we = 0; bus1.dm_addr = '0; bus1.dm_wdata = '0;
    bus4.en = 0; bus4.if_req = 0; bus4.if_addr = '0; bus4.dm_req = 0;
    bus4.dm_we = 0; bus4.dm_addr = '0; bus4.dm_wdata = '0;

    bd_we = 1; bd_addr = 11'd5; bd_data = 32'h0440_0001;
    tick();
    bd_we = 0;
    tick();

    // Reset values
    chk("rst_cs_n", bus1.mem_cs_n, 1);
    chk("rst_we_n", bus1.mem_we_n, 1);
    chk("rst_oe_n", bus1.mem_oe_n, 1);
    chk("rst_if_valid", bus1.if_valid, 0);
    chk("rst_dm_done", bus1.dm_done, 0);
    chk("rst_busy", bus1.busy, 0);
    chk("rst_if_rdata", bus1.if_rdata, 0);
    chk("rst_dm_rdata", bus1.dm_rdata, 0);
    chk("rst_mem_addr", bus1.mem_addr, 0);
    rst_n = 1; rst4_n = 1;
    tick();

    // Fetch from address 5
    bus1.en = 1; bus1.if_req = 1; bus1.if_addr = 11'd5;
    tick();
    chk("fetch_acc_cs_n", bus1.mem_cs_n, 0);
    chk("fetch_acc_oe_n", bus1.mem_oe_n, 0);
    chk("fetch_acc_we_n", bus1.mem_we_n, 1);
    chk("fetch_acc_addr", bus1.mem_addr, 5);
    chk("fetch_acc_busy", bus1.busy, 1);
    chk("fetch_acc_valid", bus1.if_valid, 0);
    chk("fetch_acc_stall", bus1.if_stall, 1);
    tick();
    chk("fetch_resp_valid", bus1.if_valid, 1);
    chk("fetch_resp_rdata", bus1.if_rdata, 32'h0440_0001);
    chk("fetch_resp_cs_n", bus1.mem_cs_n, 1);
    chk("fetch_resp_stall", bus1.if_stall, 0);
    bus1.if_req = 0;
    tick();
    chk("fetch_idle_valid", bus1.if_valid, 0);
    chk("fetch_idle_busy", bus1.busy, 0);

    // Store 42 to address 20
    bus1.dm_req = 1; bus1.dm_we = 1; bus1.dm_addr = 11'd20; bus1.dm_wdata = 32'd42;
    tick();
    chk("st_acc_we_n", bus1.mem_we_n, 0);
    chk("st_acc_oe_n", bus1.mem_oe_n, 1);
    chk("st_acc_cs_n", bus1.mem_cs_n, 0);
    chk("st_acc_wdata", bus1.mem_wdata, 42);
    chk("st_acc_stall", bus1.dm_stall, 1);
    tick();
    chk("st_resp_done", bus1.dm_done, 1);
    chk("st_resp_rdata", bus1.dm_rdata, 0);
    chk("st_resp_we_n", bus1.mem_we_n, 1);
    bus1.dm_req = 0;
    tick();

    // Load back address 20
    bus1.dm_req = 1; bus1.dm_we = 0; bus1.dm_addr = 11'd20;
    tick();
    chk("ld_acc_we_n", bus1.mem_we_n, 1);
    chk("ld_acc_oe_n", bus1.mem_oe_n, 0);
    tick();
    chk("ld_resp_done", bus1.dm_done, 1);
    chk("ld_resp_rdata", bus1.dm_rdata, 42);
    chk("ld_resp_if_rdata", bus1.if_rdata, 32'h0440_0001);
    bus1.dm_req = 0;
    tick();

    // Contention: expect DM,DM,DM,IF,DM,DM
    bus1.if_req = 1; bus1.if_addr = 11'd7;
    bus1.dm_req = 1; bus1.dm_we = 0; bus1.dm_addr = 11'd30;
    seq = 8'hFF; nev = 0; ndm = 0; stall_ok = 1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus1.if_valid) begin
        seq = {seq[6:0], 1'b1};
        nev++;
        if (bus1.if_stall !== 1'b0) stall_ok = 0;
        bus1.if_req = 0;
      end else if (bus1.if_req && bus1.if_stall !== 1'b1) begin
        stall_ok = 0;
      end
      if (bus1.dm_done) begin
        seq = {seq[6:0], 1'b0};
        nev++;
        ndm++;
        if (ndm == 5) bus1.dm_req = 0;
      end
    end
    chk("cont_order", seq, 8'hC4);
    chk("cont_events", nev, 6);
    chk("cont_if_stall", stall_ok, 1);

    // en drops during a fetch access
    bus1.en = 1; bus1.if_req = 1; bus1.if_addr = 11'd5;
    tick();
    chk("en_acc_busy", bus1.busy, 1);
    bus1.en = 0; bus1.dm_req = 1; bus1.dm_we = 0; bus1.dm_addr = 11'd20;
    tick();
    chk("en_resp_valid", bus1.if_valid, 1);
    chk("en_resp_rdata", bus1.if_rdata, 32'h0440_0001);
    bus1.if_req = 0;
    for (int c = 0; c < 3; c++) tick();
    chk("en_hold_busy", bus1.busy, 0);
    chk("en_hold_dm_stall", bus1.dm_stall, 1);
    chk("en_hold_cs_n", bus1.mem_cs_n, 1);
    bus1.en = 1;
    tick();
    chk("en_resume_busy", bus1.busy, 1);
    tick();
    chk("en_resume_done", bus1.dm_done, 1);
    chk("en_resume_rdata", bus1.dm_rdata, 42);
    bus1.dm_req = 0;
    tick();

    // Reset in cycle 2 of a latency-4 access, then re-serve
    bus4.en = 1; bus4.if_req = 1; bus4.if_addr = 11'd9;
    tick();
    tick();
    chk("rst4_pre_cs_n", bus4.mem_cs_n, 0);
    rst4_n = 0;
    #1;
    chk("rst4_cs_n", bus4.mem_cs_n, 1);
    chk("rst4_oe_n", bus4.mem_oe_n, 1);
    chk("rst4_busy", bus4.busy, 0);
    chk("rst4_valid", bus4.if_valid, 0);
    tick();
    chk("rst4_hold_valid", bus4.if_valid, 0);
    rst4_n = 1;
    low4 = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus4.mem_cs_n === 1'b0 && bus4.if_valid === 1'b0) low4++;
    end
    chk("rst4_access_cycles", low4, 4);
    tick();
    chk("rst4_resp_valid", bus4.if_valid, 1);
    chk("rst4_resp_rdata", bus4.if_rdata, 32'hA5A5_0009);
    chk("rst4_resp_cs_n", bus4.mem_cs_n, 1);
    bus4.if_req = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
